// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
//
// Data-side memory bridge behind the MEM stage. Turns the stage's single-cycle
// SRAM-style access into a split-transaction bus (request / address-ack /
// data-ack) and freezes the pipeline with cpu_stall while the access is in
// flight. Read data is returned raw (32 bits); lane extraction and sign
// extension stay in the MEM stage.
//
// Optional feature macro: DBRIDGE_TIMEOUT_EN
//   Defined   : per-transaction watchdog of TIMEOUT cycles. On expiry the
//               access completes with cpu_rdata = 0 and the sticky bus_err set.
//   Undefined : no watchdog, bus_err tied low, REQ/WAIT wait indefinitely.
//
// Parameters
//   TIMEOUT       watchdog limit in cycles (used only with DBRIDGE_TIMEOUT_EN)
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   cpu_en        MEM stage has a load/store this cycle
//   cpu_wen       byte write mask (0 = load)
//   cpu_size      access size: 0 byte, 1 half, 2 word
//   cpu_addr      byte address
//   cpu_wdata     lane-replicated store data
//   cpu_rdata     raw word of the last completed load
//   cpu_stall     hold IF..MEM this cycle
//   data_req      bus request valid
//   data_wr       1 = write
//   data_size     latched cpu_size
//   data_addr     latched address
//   data_wdata    latched store data
//   data_wstrb    latched byte mask
//   data_addr_ok  request accepted by the slave
//   data_data_ok  read data / write completion
//   data_rdata    read data, valid with data_data_ok
//   bus_err       sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module dmem_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        req_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        rd_cap;
    logic        to_fire;

`ifdef DBRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // Expiry is detected one count early so that exactly TIMEOUT cycles are
    // spent in REQ/WAIT before DONE.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;
`endif

    // Next-state logic. Data acks outside REQ+addr_ok or WAIT fall through
    // the case without effect, which is how spurious acks are ignored.
    always_comb begin
        state_d = state_q;
        rd_cap  = 1'b0;
        to_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_en) state_d = S_REQ;
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = S_DONE;
                        rd_cap  = ~wr_q;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = S_DONE;
                    rd_cap  = ~wr_q;
                end
            end
            S_DONE: begin
                // cpu_en is ignored here: the access in MEM is the one that
                // just completed.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef DBRIDGE_TIMEOUT_EN
        // A real completion on the last watchdog cycle wins over the timeout.
        if ((state_q == S_REQ || state_q == S_WAIT) && state_d != S_DONE &&
            cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            to_fire = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            // Registered request: high for exactly the cycles spent in REQ.
            req_q   <= (state_d == S_REQ);
            if (state_q == S_IDLE && cpu_en) begin
                wr_q    <= |cpu_wen;
                size_q  <= cpu_size;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                wstrb_q <= cpu_wen;
            end
            if (rd_cap) begin
                rdata_q <= data_rdata;
            end else if (to_fire) begin
                rdata_q <= 32'h0;
            end
        end
    end

`ifdef DBRIDGE_TIMEOUT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == S_REQ && state_q != S_REQ) begin
            cnt_d = '0;
        end else if (state_q == S_REQ || state_q == S_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (to_fire) err_q <= 1'b1;
        end
    end

    assign bus_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign bus_err        = 1'b0;
`endif

    assign cpu_stall  = (state_q == S_IDLE && cpu_en) ||
                        (state_q == S_REQ) || (state_q == S_WAIT);
    assign cpu_rdata  = rdata_q;
    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign data_wstrb = wstrb_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
//
// Scoreboard bench for dmem_bridge. Each issued access pushes its expected
// completion (read data, stall length, request length, bus fields, bus_err)
// into a queue; a monitor pops and compares whenever a stalled access ends.
// A small configurable slave answers requests; tests that need exact ack
// placement drive the acks by hand instead.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

`ifdef DBRIDGE_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_err;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_en       (cpu_en),
        .cpu_wen      (cpu_wen),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_err      (bus_err)
    );

    // Slave: automatic (configurable latency) or manual (driven by stimulus).
    logic        s_auto;
    int          s_r, s_w;
    logic [31:0] s_rd;
    logic        sl_aok, sl_dok;
    logic [31:0] sl_rd;
    logic        m_aok, m_dok;
    logic [31:0] m_rd;
    int          sph, scnt;

    assign data_addr_ok = s_auto ? sl_aok : m_aok;
    assign data_data_ok = s_auto ? sl_dok : m_dok;
    assign data_rdata   = s_auto ? sl_rd  : m_rd;

    typedef struct {
        logic [31:0] rdata;
        int          stall;
        int          req;
        logic        wr;
        logic [3:0]  wstrb;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_err  = 0;
    int   ev_cnt = 0;
    int   n_push = 0;
    bit   mon_en = 1'b0;

    int          mon_st, mon_rq;
    logic        c_wr;
    logic [3:0]  c_wstrb;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata;
    exp_t        mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] rd, input int st, input int rq, input logic wr,
                        input logic [3:0] ws, input logic [1:0] sz, input logic [31:0] ad,
                        input logic [31:0] wd, input logic er);
        exp_t e;
        e.rdata = rd; e.stall = st; e.req = rq; e.wr = wr; e.wstrb = ws;
        e.size = sz; e.addr = ad; e.wdata = wd; e.err = er;
        sb.push_back(e);
        n_push++;
    endtask

    task automatic issue(input logic [3:0] wen, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd);
        cpu_en = 1'b1; cpu_wen = wen; cpu_size = sz; cpu_addr = ad; cpu_wdata = wd;
        tick();
        cpu_en = 1'b0;
    endtask

    task automatic wait_ev(input string nm);
        int n = 0;
        while (ev_cnt < n_push && n < 200) begin
            tick();
            n++;
        end
        if (ev_cnt < n_push) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: completion not seen, got %0d events, expected %0d", nm, ev_cnt, n_push);
        end
    endtask

    initial begin : slave
        sph = 0; scnt = 0; sl_aok = 1'b0; sl_dok = 1'b0; sl_rd = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            sl_aok = 1'b0;
            sl_dok = 1'b0;
            if (!s_auto) begin
                sph = 0;
            end else begin
                if (sph == 0 && data_req) begin
                    sph  = 1;
                    scnt = 0;
                end
                if (sph == 1) begin
                    scnt++;
                    if (scnt == s_r) begin
                        sl_aok = 1'b1;
                        if (s_w == 0) begin
                            sl_dok = 1'b1; sl_rd = s_rd; sph = 0;
                        end else begin
                            sph = 2; scnt = 0;
                        end
                    end
                end else if (sph == 2) begin
                    scnt++;
                    if (scnt == s_w) begin
                        sl_dok = 1'b1; sl_rd = s_rd; sph = 0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        mon_st = 0; mon_rq = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cpu_stall) mon_st++;
                if (data_req) begin
                    mon_rq++;
                    c_wr = data_wr; c_wstrb = data_wstrb; c_size = data_size;
                    c_addr = data_addr; c_wdata = data_wdata;
                end
                if (!cpu_stall && mon_st > 0) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_completion: got stall of %0d cycles, expected none", mon_st);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("rdata",        cpu_rdata,       mon_e.rdata);
                        chk("stall_cycles", 32'(mon_st),     32'(mon_e.stall));
                        chk("req_cycles",   32'(mon_rq),     32'(mon_e.req));
                        chk("data_wr",      {31'h0, c_wr},   {31'h0, mon_e.wr});
                        chk("data_wstrb",   {28'h0, c_wstrb}, {28'h0, mon_e.wstrb});
                        chk("data_size",    {30'h0, c_size}, {30'h0, mon_e.size});
                        chk("data_addr",    c_addr,          mon_e.addr);
                        chk("data_wdata",   c_wdata,         mon_e.wdata);
                        chk("bus_err",      {31'h0, bus_err}, {31'h0, mon_e.err});
                    end
                    mon_st = 0;
                    mon_rq = 0;
                    ev_cnt++;
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'h0; cpu_size = 2'd0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        s_auto = 1'b1; s_r = 1; s_w = 0; s_rd = 32'h0;
        m_aok = 1'b0; m_dok = 1'b0; m_rd = 32'h0;
        repeat (3) tick();

        // Reset state
        chk("rst_data_req",   {31'h0, data_req},   32'h0);
        chk("rst_data_wr",    {31'h0, data_wr},    32'h0);
        chk("rst_data_size",  {30'h0, data_size},  32'h0);
        chk("rst_data_addr",  data_addr,           32'h0);
        chk("rst_data_wdata", data_wdata,          32'h0);
        chk("rst_data_wstrb", {28'h0, data_wstrb}, 32'h0);
        chk("rst_cpu_rdata",  cpu_rdata,           32'h0);
        chk("rst_bus_err",    {31'h0, bus_err},    32'h0);
        chk("rst_cpu_stall",  {31'h0, cpu_stall},  32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Zero-wait load
        s_r = 1; s_w = 0; s_rd = 32'hDEADBEEF;
        push(32'hDEADBEEF, 2, 1, 1'b0, 4'h0, 2'd2, 32'h1000, 32'h0, 1'b0);
        issue(4'h0, 2'd2, 32'h1000, 32'h0);
        wait_ev("load_zero_wait");

        // Delayed byte store; slave data must not reach cpu_rdata
        s_r = 2; s_w = 3; s_rd = 32'h12345678;
        push(32'hDEADBEEF, 6, 2, 1'b1, 4'b0100, 2'd0, 32'h2002, 32'h55555555, 1'b0);
        issue(4'b0100, 2'd0, 32'h2002, 32'h55555555);
        wait_ev("store_delayed");

        // Delayed load
        s_r = 3; s_w = 1; s_rd = 32'hCAFEF00D;
        push(32'hCAFEF00D, 5, 3, 1'b0, 4'h0, 2'd2, 32'h3004, 32'h0, 1'b0);
        issue(4'h0, 2'd2, 32'h3004, 32'h0);
        wait_ev("load_delayed");

        // Back-to-back load then store with cpu_en held high
        s_r = 1; s_w = 0; s_rd = 32'h0BADF00D;
        push(32'h0BADF00D, 2, 1, 1'b0, 4'h0, 2'd2, 32'h4000, 32'h0, 1'b0);
        push(32'h0BADF00D, 2, 1, 1'b1, 4'hF, 2'd2, 32'h4008, 32'hA5A5A5A5, 1'b0);
        cpu_en = 1'b1; cpu_wen = 4'h0; cpu_size = 2'd2; cpu_addr = 32'h4000; cpu_wdata = 32'h0;
        tick();
        tick();
        chk("b2b_done_stall", {31'h0, cpu_stall}, 32'h0);
        cpu_wen = 4'hF; cpu_addr = 32'h4008; cpu_wdata = 32'hA5A5A5A5;
        tick();
        chk("b2b_idle_stall", {31'h0, cpu_stall}, 32'h1);
        chk("b2b_idle_noreq", {31'h0, data_req},  32'h0);
        tick();
        cpu_en = 1'b0;
        wait_ev("back_to_back");

        // Spurious data_ok in IDLE and in REQ without addr_ok
        s_auto = 1'b0;
        tick();
        m_dok = 1'b1; m_rd = 32'hFFFFFFFF;
        tick();
        m_dok = 1'b0;
        chk("spur_idle_stall", {31'h0, cpu_stall}, 32'h0);
        chk("spur_idle_noreq", {31'h0, data_req},  32'h0);
        chk("spur_idle_rdata", cpu_rdata, 32'h0BADF00D);
        push(32'h22222222, 3, 2, 1'b0, 4'h0, 2'd2, 32'h5000, 32'h0, 1'b0);
        issue(4'h0, 2'd2, 32'h5000, 32'h0);
        m_dok = 1'b1; m_rd = 32'h11111111;
        tick();
        chk("spur_req_held",  {31'h0, data_req}, 32'h1);
        chk("spur_req_rdata", cpu_rdata, 32'h0BADF00D);
        m_aok = 1'b1; m_dok = 1'b1; m_rd = 32'h22222222;
        tick();
        m_aok = 1'b0; m_dok = 1'b0;
        wait_ev("spurious_then_load");

        // Reset while in WAIT, late data_ok afterwards
        s_auto = 1'b1; s_r = 1; s_w = 50; s_rd = 32'h33333333;
        tick();
        push(32'h0, 4, 1, 1'b0, 4'h0, 2'd2, 32'h6000, 32'h0, 1'b0);
        issue(4'h0, 2'd2, 32'h6000, 32'h0);
        tick();
        tick();
        chk("wait_noreq", {31'h0, data_req},  32'h0);
        chk("wait_stall", {31'h0, cpu_stall}, 32'h1);
        s_auto = 1'b0; m_aok = 1'b0; m_dok = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; m_dok = 1'b1; m_rd = 32'h44444444;
        tick();
        m_dok = 1'b0;
        chk("postrst_stall", {31'h0, cpu_stall}, 32'h0);
        chk("postrst_noreq", {31'h0, data_req},  32'h0);
        chk("postrst_rdata", cpu_rdata, 32'h0);
        wait_ev("reset_mid_wait");

`ifdef DBRIDGE_TIMEOUT_EN
        // Load to make cpu_rdata nonzero, then a request that is never accepted
        s_auto = 1'b1; s_r = 1; s_w = 0; s_rd = 32'h77777777;
        tick();
        push(32'h77777777, 2, 1, 1'b0, 4'h0, 2'd2, 32'h7000, 32'h0, 1'b0);
        issue(4'h0, 2'd2, 32'h7000, 32'h0);
        wait_ev("pre_timeout_load");
        s_auto = 1'b0;
        tick();
        push(32'h0, 1 + TO, TO, 1'b0, 4'h0, 2'd2, 32'h7004, 32'h0, 1'b1);
        issue(4'h0, 2'd2, 32'h7004, 32'h0);
        wait_ev("timeout");
        repeat (3) tick();
        chk("err_sticky", {31'h0, bus_err}, 32'h1);
        // A normal load afterwards completes and leaves bus_err set
        s_auto = 1'b1; s_r = 1; s_w = 0; s_rd = 32'h88888888;
        tick();
        push(32'h88888888, 2, 1, 1'b0, 4'h0, 2'd2, 32'h7008, 32'h0, 1'b1);
        issue(4'h0, 2'd2, 32'h7008, 32'h0);
        wait_ev("post_timeout_load");
`else
        chk("bus_err_tied", {31'h0, bus_err}, 32'h0);
`endif

        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side memory bridge placed directly downstream of the pipeline's MEM stage. It accepts the stage's single-cycle SRAM-style access (enable, byte mask, address, write data) and converts it into a split-transaction request/address-ack/data-ack bus. While a transaction is outstanding it freezes the pipeline through `cpu_stall`. It returns raw 32-bit read data; the MEM stage keeps doing byte/halfword lane extraction and sign extension.

## Interface
Parameters:
- `TIMEOUT`, 255: watchdog limit in cycles, counted per transaction. Used only when `DBRIDGE_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_en`  in  1  MEM stage has a load or store this cycle.
- `cpu_wen`  in  4  byte write mask; 0 means load.
- `cpu_size`  in  2  access size: 0 byte, 1 half, 2 word.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  lane-replicated store data.
- `cpu_rdata`  out  32  raw word from the last completed load.
- `cpu_stall`  out  1  hold IF through MEM this cycle.
- `data_req`  out  1  bus request valid.
- `data_wr`  out  1  1 = write.
- `data_size`  out  2  copy of the latched `cpu_size`.
- `data_addr`  out  32  latched address.
- `data_wdata`  out  32  latched write data.
- `data_wstrb`  out  4  latched `cpu_wen`.
- `data_addr_ok`  in  1  request accepted.
- `data_data_ok`  in  1  response / write completion.
- `data_rdata`  in  32  read data, valid with `data_data_ok`.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- State machine with four states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If `cpu_en`=1, latch addr/wdata/wen/size and set `data_wr` = |`cpu_wen`; next state REQ.
  - `cpu_en`=0: stay in IDLE.
- REQ:
  - `data_req`=1; all `data_*` outputs are held stable from the latches.
  - `data_addr_ok`=1 and `data_data_ok`=1 in the same cycle: capture `data_rdata` if it is a read; next state DONE.
  - `data_addr_ok`=1 alone: next state WAIT.
  - Otherwise stay in REQ.
- WAIT:
  - `data_req`=0.
  - `data_data_ok`=1: capture `data_rdata` if it is a read; next state DONE.
- DONE:
  - `cpu_stall`=0 so the pipeline advances at this edge.
  - `cpu_en` is ignored in this state; the access now in MEM is the one just completed.
  - Next state is always IDLE.
- `cpu_stall` = (IDLE & `cpu_en`) | REQ | WAIT. This is combinational from state and `cpu_en`.
- `cpu_rdata` changes only on a read capture. Writes leave it unchanged.
- `data_data_ok` arriving in IDLE, or in REQ without `data_addr_ok`, is ignored.
- Only one transaction is ever outstanding; `data_req` is never asserted in WAIT or DONE.
- No address alignment checking; the address is forwarded as given.

## Timing
- Reset values:
  - state IDLE.
  - `data_req`, `data_wr` = 0.
  - `data_size` = 0.
  - `data_addr`, `data_wdata`, `cpu_rdata` = 0.
  - `data_wstrb` = 0.
  - `bus_err` = 0.
  - watchdog counter = 0.
- `data_*` outputs are registered. `data_req` rises one cycle after IDLE sees `cpu_en`.
- Minimum access is 3 cycles:
  - cycle 0: IDLE, stall=1.
  - cycle 1: REQ, with addr_ok and data_ok both seen.
  - cycle 2: DONE, stall=0.
- With ack delays: stall cycles = 1 + (cycles in REQ) + (cycles in WAIT).
- `rst` in any state returns the block to IDLE on the next edge and abandons the transaction. A late `data_data_ok` after reset is ignored.
- Back-to-back accesses: after DONE there is one IDLE cycle, which already raises stall if `cpu_en`=1.

## Configuration
- Macro: `DBRIDGE_TIMEOUT_EN`.
- Defined:
  - An 8+ bit counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT`, the FSM goes to DONE with `cpu_rdata` forced to 32'h0 and `bus_err` set to 1.
  - `bus_err` stays set until `rst`.
- Not defined:
  - No counter is built and `bus_err` is tied to 0.
  - REQ and WAIT wait indefinitely.

## Test plan
- Load, zero-wait: `cpu_en`=1, `cpu_wen`=0, addr 0x1000; slave gives addr_ok+data_ok in the first REQ cycle with rdata 0xDEADBEEF -> stall high for 2 cycles, DONE on cycle 2, `cpu_rdata`=0xDEADBEEF, `data_req` high for exactly 1 cycle.
- Store, delayed: `cpu_wen`=4'b0100, size 0, addr 0x2002, wdata 0x55555555; addr_ok after 2 cycles, data_ok 3 cycles later -> `data_wr`=1, `data_wstrb`=0100, stall held 6 cycles, `cpu_rdata` unchanged.
- Back-to-back: a load followed by a store with `cpu_en` held high -> two distinct REQ phases, with exactly one DONE and one IDLE cycle between them.
- Spurious acks: data_ok pulsed in IDLE, and in REQ without addr_ok -> no state change and `cpu_rdata` unchanged.
- Reset mid-WAIT: assert `rst` in WAIT, then send data_ok one cycle after reset -> state IDLE, stall 0, `cpu_rdata`=0.
- Timeout (`DBRIDGE_TIMEOUT_EN`, `TIMEOUT`=4): addr_ok never arrives -> DONE after 4 REQ cycles, `bus_err`=1 and stays 1, `cpu_rdata`=0.
